// File: rtl/match_pkg.sv
// Shared types and constants for the tug-of-war match scorer.
// State encoding, winner codes and active-low seven-segment digits {g..a}.
package match_pkg;

  typedef enum logic [1:0] {
    PLAY,
    CLEAR,
    MATCH_OVER
  } state_t;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] LEFT  = 2'b01;
  localparam logic [1:0] RIGHT = 2'b10;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_hex.sv
// Hex digit to active-low seven-segment decoder, segments {g..a}.
// Ports: digit (4-bit value in), seg (7-bit active-low segments out).
module seg7_hex
  import match_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    unique case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/match_scorer.sv
// Round/match scorekeeper: counts round wins, pulses gameReset, ends match.
// Ports: Clock, Reset, LeftEnd, RightEnd, L, R, NewMatch in; HEX5, HEX0, gameReset, matchOver, winner out.
module match_scorer
  import match_pkg::*;
#(
  parameter int SCORE_W     = 3,
  parameter int WIN_ROUNDS  = 5,
  parameter int HOLD_CYCLES = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       LeftEnd,
  input  logic       RightEnd,
  input  logic       L,
  input  logic       R,
  input  logic       NewMatch,
  output logic [6:0] HEX5,
  output logic [6:0] HEX0,
  output logic       gameReset,
  output logic       matchOver,
  output logic [1:0] winner
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_ROUNDS);

  state_t             state;
  logic [HW-1:0]      hold;
  logic [SCORE_W-1:0] lscore;
  logic [SCORE_W-1:0] rscore;

  logic               leftWin;
  logic               rightWin;
  logic [SCORE_W-1:0] lnext;
  logic [SCORE_W-1:0] rnext;

  // Simultaneous presses cancel, so at most one side can win.
  assign leftWin  = LeftEnd & L & ~R;
  assign rightWin = RightEnd & R & ~L;
  assign lnext    = lscore + SCORE_W'(1);
  assign rnext    = rscore + SCORE_W'(1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= PLAY;
      hold      <= '0;
      lscore    <= '0;
      rscore    <= '0;
      gameReset <= 1'b0;
      matchOver <= 1'b0;
      winner    <= NONE;
    end else if (NewMatch) begin
      state     <= CLEAR;
      hold      <= HOLD_LOAD;
      lscore    <= '0;
      rscore    <= '0;
      gameReset <= 1'b1;
      matchOver <= 1'b0;
      winner    <= NONE;
    end else begin
      unique case (state)
        PLAY: begin
          unique case (1'b1)
            leftWin: begin
              lscore    <= lnext;
              gameReset <= 1'b1;
              if (lnext == WIN_S) begin
                state     <= MATCH_OVER;
                matchOver <= 1'b1;
                winner    <= LEFT;
              end else begin
                state <= CLEAR;
                hold  <= HOLD_LOAD;
              end
            end
            rightWin: begin
              rscore    <= rnext;
              gameReset <= 1'b1;
              if (rnext == WIN_S) begin
                state     <= MATCH_OVER;
                matchOver <= 1'b1;
                winner    <= RIGHT;
              end else begin
                state <= CLEAR;
                hold  <= HOLD_LOAD;
              end
            end
            default: ;
          endcase
        end
        CLEAR: begin
          if (hold == '0) begin
            state     <= PLAY;
            gameReset <= 1'b0;
          end else begin
            hold <= hold - HW'(1);
          end
        end
        MATCH_OVER: ;
        default: begin
          state     <= PLAY;
          gameReset <= 1'b0;
        end
      endcase
    end
  end

  seg7_hex u_left (
    .digit(4'(lscore)),
    .seg  (HEX5)
  );

  seg7_hex u_right (
    .digit(4'(rscore)),
    .seg  (HEX0)
  );

endmodule
